// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM session controller.
package atm_pkg;

   // Session controller states; the encoding is what state_o reports.
   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StPin      = 3'd1,
      StBio      = 3'd2,
      StAmount   = 3'd3,
      StDispense = 3'd4,
      StLocked   = 3'd5
   } atm_state_e;

   // Error codes reported on err_code.
   typedef enum logic [2:0] {
      ErrNone      = 3'd0,
      ErrBadPin    = 3'd1,
      ErrLocked    = 3'd2,
      ErrBioFail   = 3'd3,
      ErrBadAmount = 3'd4,
      ErrTimeout   = 3'd5,
      ErrCancel    = 3'd6,
      ErrLimit     = 3'd7
   } atm_err_e;

   localparam logic [3:0] ATM_DEFAULT_PIN = 4'b1010;
   localparam logic [7:0] ATM_MAX_AMOUNT  = 8'd100;

endpackage

// File: rtl/atm_session_ctrl_if.sv
// Host/dispenser signal bundle of the ATM session controller.
// master: the card reader, keypad, biometric unit and dispenser side.
// slave:  the session controller itself.
interface atm_session_ctrl_if;

   logic       card_inserted;
   logic       cancel;
   logic       pin_valid;
   logic [3:0] pin_input;
   logic       bio_valid;
   logic       bio_ok;
   logic       amt_valid;
   logic [7:0] amount;
   logic       disp_req;
   logic [7:0] disp_amount;
   logic       disp_ready;
   logic [2:0] state_o;
   logic       session_active;
   logic       txn_done;
   logic       txn_error;
   logic [2:0] err_code;
   logic       locked;

   modport master (
      output card_inserted, cancel, pin_valid, pin_input, bio_valid, bio_ok,
             amt_valid, amount, disp_ready,
      input  disp_req, disp_amount, state_o, session_active, txn_done,
             txn_error, err_code, locked
   );

   modport slave (
      input  card_inserted, cancel, pin_valid, pin_input, bio_valid, bio_ok,
             amt_valid, amount, disp_ready,
      output disp_req, disp_amount, state_o, session_active, txn_done,
             txn_error, err_code, locked
   );

endinterface

// File: rtl/atm_inactivity_timer.sv
// Inactivity timer: counts quiet cycles while run is high and flags expiry
// on the TIMEOUT_CYCLES-th quiet cycle after the last reload.
module atm_inactivity_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic run,
   input  logic reload,
   output logic expired
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count_q, count_d;

   // Reload wins; otherwise advance while running, parking on the terminal value.
   always_comb begin
      count_d = count_q;
      if (reload) begin
         count_d = '0;
      end else if (run && (count_q != LAST)) begin
         count_d = count_q + CW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = run && (count_q == LAST);

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session controller: card -> PIN -> biometric -> amount -> dispense.
// Optional feature: define ATM_DAILY_LIMIT_EN to enforce a cumulative
// dispense ceiling (DAILY_LIMIT) with error code LIMIT.
module atm_session_ctrl
   import atm_pkg::*;
#(
   parameter logic [3:0]  DEFAULT_PIN      = ATM_DEFAULT_PIN,
   parameter int unsigned MAX_PIN_ATTEMPTS = 3,
   parameter logic [7:0]  MAX_AMOUNT       = ATM_MAX_AMOUNT,
   parameter int unsigned TIMEOUT_CYCLES   = 1000,
   parameter logic [15:0] DAILY_LIMIT      = 16'd500
) (
   input logic           clk,
   input logic           reset_n,
   atm_session_ctrl_if.slave host
);

   localparam int unsigned   AW       = $clog2(MAX_PIN_ATTEMPTS + 1);
   localparam logic [AW-1:0] ATT_LAST = AW'(MAX_PIN_ATTEMPTS - 1);

   atm_state_e    state_q, state_d;
   logic [AW-1:0] attempts_q, attempts_d;
   logic [3:0]    pin_q;
   logic [7:0]    amount_q, amount_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
   atm_err_e      code_q, code_d;

   logic abort, any_strobe, timeout, expired, run_timer, reload_timer, amount_bad;
   logic disp_req, session_active, locked;

`ifdef ATM_DAILY_LIMIT_EN
   logic [15:0] total_q, total_d;
   logic [16:0] total_req, total_add;
   logic        over_limit;

   assign total_req  = {1'b0, total_q} + {9'd0, host.amount};
   assign total_add  = {1'b0, total_q} + {9'd0, amount_q};
   assign over_limit = total_req > {1'b0, DAILY_LIMIT};
`else
   logic unused_daily_limit;
   assign unused_daily_limit = ^DAILY_LIMIT;
`endif

   assign abort      = host.cancel || !host.card_inserted;
   assign any_strobe = host.pin_valid || host.bio_valid || host.amt_valid;
   // Any strobe outranks expiry in the same cycle.
   assign timeout    = expired && !any_strobe;
   assign amount_bad = (host.amount == 8'd0) || (host.amount > MAX_AMOUNT);

   assign run_timer    = (state_q == StPin) || (state_q == StBio) || (state_q == StAmount);
   assign reload_timer = (state_d != state_q) || any_strobe;

   atm_inactivity_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .reset_n(reset_n),
      .run    (run_timer),
      .reload (reload_timer),
      .expired(expired)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state plus the event (done/error/code) and datapath updates it implies.
   always_comb begin
      state_d    = state_q;
      attempts_d = attempts_q;
      amount_d   = amount_q;
      done_d     = 1'b0;
      error_d    = 1'b0;
      code_d     = code_q;
`ifdef ATM_DAILY_LIMIT_EN
      total_d    = total_q;
`endif
      case (state_q)
         StIdle: begin
            if (host.card_inserted) state_d = StPin;
         end
         StPin: begin
            if (abort) begin
               state_d = StIdle;
               error_d = 1'b1;
               code_d  = ErrCancel;
            end else if (host.pin_valid) begin
               if (host.pin_input == pin_q) begin
                  state_d    = StBio;
                  attempts_d = '0;
               end else begin
                  attempts_d = attempts_q + AW'(1);
                  error_d    = 1'b1;
                  if (attempts_q >= ATT_LAST) begin
                     state_d = StLocked;
                     code_d  = ErrLocked;
                  end else begin
                     code_d  = ErrBadPin;
                  end
               end
            end else if (timeout) begin
               state_d = StIdle;
               error_d = 1'b1;
               code_d  = ErrTimeout;
            end
         end
         StBio: begin
            if (abort) begin
               state_d = StIdle;
               error_d = 1'b1;
               code_d  = ErrCancel;
            end else if (host.bio_valid) begin
               if (host.bio_ok) begin
                  state_d = StAmount;
               end else begin
                  state_d = StIdle;
                  error_d = 1'b1;
                  code_d  = ErrBioFail;
               end
            end else if (timeout) begin
               state_d = StIdle;
               error_d = 1'b1;
               code_d  = ErrTimeout;
            end
         end
         StAmount: begin
            if (abort) begin
               state_d = StIdle;
               error_d = 1'b1;
               code_d  = ErrCancel;
            end else if (host.amt_valid) begin
               if (amount_bad) begin
                  error_d = 1'b1;
                  code_d  = ErrBadAmount;
`ifdef ATM_DAILY_LIMIT_EN
               end else if (over_limit) begin
                  error_d = 1'b1;
                  code_d  = ErrLimit;
`endif
               end else begin
                  state_d  = StDispense;
                  amount_d = host.amount;
               end
            end else if (timeout) begin
               state_d = StIdle;
               error_d = 1'b1;
               code_d  = ErrTimeout;
            end
         end
         StDispense: begin
            // Cancel and card removal are ignored so the handshake always completes.
            if (host.disp_ready) begin
               state_d = StIdle;
               done_d  = 1'b1;
               code_d  = ErrNone;
`ifdef ATM_DAILY_LIMIT_EN
               total_d = total_add[16] ? 16'hFFFF : total_add[15:0];
`endif
            end
         end
         StLocked: begin
            if (any_strobe) begin
               error_d = 1'b1;
               code_d  = ErrLocked;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Datapath and event registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         attempts_q <= '0;
         pin_q      <= DEFAULT_PIN;
         amount_q   <= '0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         code_q     <= ErrNone;
`ifdef ATM_DAILY_LIMIT_EN
         total_q    <= '0;
`endif
      end else begin
         attempts_q <= attempts_d;
         pin_q      <= pin_q;  // no change-PIN path; holds the reset value
         amount_q   <= amount_d;
         done_q     <= done_d;
         error_q    <= error_d;
         code_q     <= code_d;
`ifdef ATM_DAILY_LIMIT_EN
         total_q    <= total_d;
`endif
      end
   end

   // State-decoded outputs.
   always_comb begin
      disp_req       = (state_q == StDispense);
      locked         = (state_q == StLocked);
      session_active = (state_q == StPin) || (state_q == StBio) ||
                       (state_q == StAmount) || (state_q == StDispense);
   end

   assign host.state_o        = state_q;
   assign host.disp_req       = disp_req;
   assign host.disp_amount    = amount_q;
   assign host.session_active = session_active;
   assign host.locked         = locked;
   assign host.txn_done       = done_q;
   assign host.txn_error      = error_q;
   assign host.err_code       = code_q;

endmodule

// File: doc/atm_session_ctrl.md
ATM_SESSION_CTRL -- requirements
Module: atm_session_ctrl

Interface
REQ-001 SHALL have parameter DEFAULT_PIN, 4'b1010, PIN loaded at reset.
REQ-002 SHALL have parameter MAX_PIN_ATTEMPTS, 3, consecutive wrong PINs before lock.
REQ-003 SHALL have parameter MAX_AMOUNT, 8'd100, per-transaction ceiling.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, 1000, inactivity limit in clk cycles.
REQ-005 SHALL have parameter DAILY_LIMIT, 16'd500, cumulative dispense ceiling (see REQ-024).
REQ-006 SHALL have ports: clk in 1 clock; reset_n in 1 asynchronous active-low reset.
REQ-007 SHALL have ports: card_inserted in 1 level; cancel in 1 level; pin_valid in 1 strobe; pin_input in 4 entered PIN.
REQ-008 SHALL have ports: bio_valid in 1 strobe; bio_ok in 1 biometric result; amt_valid in 1 strobe; amount in 8 requested amount.
REQ-009 SHALL have ports: disp_req out 1; disp_amount out 8; disp_ready in 1 (dispenser handshake).
REQ-010 SHALL have ports: state_o out 3 current state; session_active out 1; txn_done out 1 pulse; txn_error out 1 pulse; err_code out 3; locked out 1.

Function
REQ-011 SHALL implement states IDLE, PIN, BIO, AMOUNT, DISPENSE, LOCKED; all transitions registered, one cycle after the sampled input.
REQ-012 IDLE: card_inserted=1 -> PIN, timer reloaded.
REQ-013 PIN: pin_valid with pin_input==stored PIN -> BIO, attempts cleared; mismatch -> attempts+1, txn_error pulse, err_code BAD_PIN(1), remain PIN; the mismatch reaching MAX_PIN_ATTEMPTS -> LOCKED, err_code LOCKED(2).
REQ-014 BIO: bio_valid&bio_ok -> AMOUNT; bio_valid&!bio_ok -> IDLE, BIO_FAIL(3).
REQ-015 AMOUNT: amt_valid with 0<amount<=MAX_AMOUNT -> DISPENSE, disp_amount latched; amount 0 or >MAX_AMOUNT -> stay AMOUNT, BAD_AMOUNT(4).
REQ-016 DISPENSE: disp_req held 1, disp_amount stable, until disp_ready sampled 1; then disp_req 0, txn_done pulse, -> IDLE.
REQ-017 LOCKED: locked=1, any pin_valid/amt_valid/bio_valid yields txn_error with LOCKED(2); exit only by reset.
REQ-018 Inactivity timer SHALL run in PIN/BIO/AMOUNT, reload on any valid strobe or state entry; reaching TIMEOUT_CYCLES -> IDLE, TIMEOUT(5); timer frozen in IDLE/DISPENSE/LOCKED.
REQ-019 cancel=1 or card_inserted=0 in PIN/BIO/AMOUNT -> IDLE, CANCEL(6); ignored in DISPENSE (handshake completes) and LOCKED.
REQ-020 Priority same cycle: cancel/card removal > valid strobe > timer expiry.
REQ-021 txn_done/txn_error SHALL be single-cycle pulses, mutually exclusive; err_code holds last error until next error or txn_done (cleared to NONE 0).
REQ-022 session_active=1 in PIN, BIO, AMOUNT, DISPENSE.

Reset
REQ-023 reset_n low SHALL force IDLE, PIN=DEFAULT_PIN, attempts=0, timer=0, daily total=0, all outputs 0, immediately and regardless of state (including mid-handshake).

Configuration
REQ-024 With ATM_DAILY_LIMIT_EN defined: 16-bit running total of dispensed amounts; amount accepted only if total+amount<=DAILY_LIMIT, else stay AMOUNT with LIMIT(7); total added on txn_done, saturating at 16'hFFFF.
REQ-025 Without ATM_DAILY_LIMIT_EN: no total register, LIMIT never produced.

Structure
REQ-026 Package atm_pkg SHALL hold the state enum, 3-bit error-code enum (NONE..LIMIT), and DEFAULT_PIN/MAX_AMOUNT constants.
REQ-027 Inactivity counter SHALL be sub-module atm_inactivity_timer (inputs run, reload; output expired).

Verification
REQ-028 Card in, PIN 1010, bio_ok=1, amount 50, disp_ready after 3 cycles -> disp_amount=50, one txn_done, back to IDLE.
REQ-029 Three PINs 0001 -> BAD_PIN twice then LOCKED, locked=1; subsequent PIN 1010 -> txn_error LOCKED; reset_n low -> IDLE, locked=0.
REQ-030 Amount 0 then 101 -> two BAD_AMOUNT errors, still AMOUNT; amount 100 -> DISPENSE.
REQ-031 TIMEOUT_CYCLES=8, no strobe in BIO for 8 cycles -> IDLE, TIMEOUT; strobe at cycle 7 -> no timeout.
REQ-032 cancel and pin_valid same cycle in PIN -> CANCEL, attempts unchanged; card removal during DISPENSE -> handshake completes, txn_done.
REQ-033 ATM_DAILY_LIMIT_EN, DAILY_LIMIT=150: dispense 100 then 60 -> LIMIT; 50 -> accepted.
